// File: rtl/lcd_pkg.sv
// Shared types, opcode/mask constants and address helpers for the LCD bus responder.
`timescale 1ns/1ps
package lcd_pkg;

    localparam int         DDRAM_DEPTH = 80;
    localparam logic [6:0] AC_MAX      = 7'(DDRAM_DEPTH - 1);
    localparam logic [7:0] CLEAR_CHAR  = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_BUSY
    } state_t;

    typedef enum logic [3:0] {
        CMD_NONE,
        CMD_CLEAR,
        CMD_HOME,
        CMD_ENTRY,
        CMD_DISP,
        CMD_SHIFT,
        CMD_FUNC,
        CMD_CGRAM,
        CMD_DDRAM
    } cmd_t;

    localparam logic [7:0] OP_DDRAM = 8'h80, MASK_DDRAM = 8'h80;
    localparam logic [7:0] OP_CGRAM = 8'h40, MASK_CGRAM = 8'hC0;
    localparam logic [7:0] OP_FUNC  = 8'h20, MASK_FUNC  = 8'hE0;
    localparam logic [7:0] OP_SHIFT = 8'h10, MASK_SHIFT = 8'hF0;
    localparam logic [7:0] OP_DISP  = 8'h08, MASK_DISP  = 8'hF8;
    localparam logic [7:0] OP_ENTRY = 8'h04, MASK_ENTRY = 8'hFC;
    localparam logic [7:0] OP_HOME  = 8'h02, MASK_HOME  = 8'hFE;
    localparam logic [7:0] OP_CLEAR = 8'h01, MASK_CLEAR = 8'hFF;

    // Leading-one decode: the highest set bit selects the instruction.
    function automatic cmd_t decode_cmd(input logic [7:0] d);
        cmd_t c;
        if      ((d & MASK_DDRAM) == OP_DDRAM) c = CMD_DDRAM;
        else if ((d & MASK_CGRAM) == OP_CGRAM) c = CMD_CGRAM;
        else if ((d & MASK_FUNC)  == OP_FUNC)  c = CMD_FUNC;
        else if ((d & MASK_SHIFT) == OP_SHIFT) c = CMD_SHIFT;
        else if ((d & MASK_DISP)  == OP_DISP)  c = CMD_DISP;
        else if ((d & MASK_ENTRY) == OP_ENTRY) c = CMD_ENTRY;
        else if ((d & MASK_HOME)  == OP_HOME)  c = CMD_HOME;
        else if ((d & MASK_CLEAR) == OP_CLEAR) c = CMD_CLEAR;
        else                                   c = CMD_NONE;
        return c;
    endfunction

    function automatic logic [6:0] step_ac(input logic [6:0] a, input logic inc);
        logic [6:0] n;
        if (inc) n = (a == AC_MAX) ? 7'd0 : a + 7'd1;
        else     n = (a == 7'd0) ? AC_MAX : a - 7'd1;
        return n;
    endfunction

    function automatic logic [6:0] clamp_ac(input logic [6:0] a);
        return (a > AC_MAX) ? AC_MAX : a;
    endfunction

endpackage

// File: rtl/lcd_sync.sv
// Two-flop synchronizer for the LCD bus pins plus falling-edge detect on E.
`timescale 1ns/1ps
module lcd_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_e,
    input  logic       i_rs,
    input  logic       i_rw,
    input  logic [7:0] i_data,
    output logic       o_e,
    output logic       o_rs,
    output logic       o_rw,
    output logic [7:0] o_data,
    output logic       o_strobe
);
    logic [10:0] r_meta;
    logic [10:0] r_sync;
    logic        r_e_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= '0;
            r_sync <= '0;
            r_e_d  <= 1'b0;
        end else begin
            r_meta <= {i_e, i_rs, i_rw, i_data};
            r_sync <= r_meta;
            r_e_d  <= r_sync[10];
        end
    end

    assign o_e      = r_sync[10];
    assign o_rs     = r_sync[9];
    assign o_rw     = r_sync[8];
    assign o_data   = r_sync[7:0];
    assign o_strobe = r_e_d & ~r_sync[10];
endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-style bus target: command decode, busy timing, 80-byte DDRAM.
// Bus reads (busy/AC and DDRAM) exist only when LCD_RESP_READ_EN is defined.
`timescale 1ns/1ps
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_CYCLES      = 2000,
    parameter int LONG_BUSY_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RS,
    input  logic       RW,
    input  logic       E,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       id_inc,
    output logic       shift_en,
    output logic       dl_8bit,
    output logic       n_lines,
    input  logic [6:0] disp_rd_addr,
    output logic [7:0] disp_rd_data,
    output logic       err_busy
);
    // Counter loads are two short of the busy length: DECODE and the final
    // zero-count cycle of BUSY both count as busy.
    localparam logic [16:0] LOAD_SHORT = 17'(BUSY_CYCLES - 2);
    localparam logic [16:0] LOAD_LONG  = 17'(LONG_BUSY_CYCLES - 2);

    logic       w_e, w_rs, w_rw, w_strobe;
    logic [7:0] w_data;
    state_t     r_state, w_next;
    logic       r_cmd_rs;
    logic [7:0] r_cmd_data;
    cmd_t       w_cmd;
    logic [16:0] r_cnt;
    logic [6:0] r_clr_addr;
    logic       w_busy, w_accept, w_rd_step, w_clr_last;
    logic       w_mem_we;
    logic [6:0] w_mem_addr;
    logic [7:0] w_mem_wdata;
    logic [7:0] r_ddram [DDRAM_DEPTH];
    logic [7:0] r_disp_rd;

    lcd_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .i_e      (E),
        .i_rs     (RS),
        .i_rw     (RW),
        .i_data   (data_in),
        .o_e      (w_e),
        .o_rs     (w_rs),
        .o_rw     (w_rw),
        .o_data   (w_data),
        .o_strobe (w_strobe)
    );

    assign w_cmd      = decode_cmd(r_cmd_data);
    assign w_accept   = w_strobe & ~w_rw & (w_rs | (w_data != 8'h00));
    assign w_clr_last = (r_clr_addr == AC_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = ST_DECODE;
            ST_DECODE: w_next = (!r_cmd_rs && w_cmd == CMD_CLEAR) ? ST_EXEC : ST_BUSY;
            ST_EXEC:   if (w_clr_last) w_next = ST_BUSY;
            ST_BUSY:   if (r_cnt == 17'd0) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = (r_state != ST_IDLE);
        w_mem_we    = 1'b0;
        w_mem_addr  = ac;
        w_mem_wdata = r_cmd_data;
        if (r_state == ST_EXEC) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_clr_addr;
            w_mem_wdata = CLEAR_CHAR;
        end else if (r_state == ST_DECODE && r_cmd_rs) begin
            w_mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmd_rs   <= 1'b0;
            r_cmd_data <= 8'h00;
            r_cnt      <= '0;
            r_clr_addr <= '0;
        end else begin
            if (r_state == ST_IDLE && w_accept) begin
                r_cmd_rs   <= w_rs;
                r_cmd_data <= w_data;
            end
            case (r_state)
                ST_DECODE: begin
                    r_clr_addr <= '0;
                    r_cnt <= (!r_cmd_rs && w_cmd == CMD_HOME) ? LOAD_LONG : LOAD_SHORT;
                end
                ST_EXEC: begin
                    r_clr_addr <= r_clr_addr + 7'd1;
                    if (w_clr_last) r_cnt <= LOAD_LONG;
                end
                ST_BUSY: if (r_cnt != 17'd0) r_cnt <= r_cnt - 17'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ac        <= 7'd0;
            disp_on   <= 1'b0;
            cursor_on <= 1'b0;
            blink_on  <= 1'b0;
            id_inc    <= 1'b1;
            shift_en  <= 1'b0;
            dl_8bit   <= 1'b1;
            n_lines   <= 1'b0;
            err_busy  <= 1'b0;
        end else begin
            if (w_strobe && !w_rw && w_busy) err_busy <= 1'b1;
            if (w_rd_step) ac <= step_ac(ac, id_inc);
            if (r_state == ST_DECODE) begin
                if (r_cmd_rs) begin
                    ac <= step_ac(ac, id_inc);
                end else begin
                    case (w_cmd)
                        CMD_HOME:  ac <= 7'd0;
                        CMD_ENTRY: {id_inc, shift_en} <= r_cmd_data[1:0];
                        CMD_DISP:  {disp_on, cursor_on, blink_on} <= r_cmd_data[2:0];
                        CMD_FUNC:  {dl_8bit, n_lines} <= r_cmd_data[4:3];
                        CMD_DDRAM: ac <= clamp_ac(r_cmd_data[6:0]);
                        default:   ;
                    endcase
                end
            end
            if (r_state == ST_EXEC && w_clr_last) begin
                ac     <= 7'd0;
                id_inc <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) r_ddram[w_mem_addr] <= w_mem_wdata;
        r_disp_rd <= (disp_rd_addr <= AC_MAX) ? r_ddram[disp_rd_addr] : 8'h00;
    end

    assign disp_rd_data = r_disp_rd;
    assign busy         = w_busy;

`ifdef LCD_RESP_READ_EN
    logic [7:0] r_rd_word;
    logic [7:0] r_data_out;
    logic       r_data_oe;

    assign w_rd_step = w_strobe & w_rw & w_rs & (r_state == ST_IDLE);

    always_ff @(posedge clk) begin
        r_rd_word <= r_ddram[ac];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_out <= 8'h00;
            r_data_oe  <= 1'b0;
        end else begin
            r_data_oe  <= w_e & w_rw;
            r_data_out <= (w_e && w_rw) ? (w_rs ? r_rd_word : {w_busy, ac}) : 8'h00;
        end
    end

    assign data_out = r_data_out;
    assign data_oe  = r_data_oe;
`else
    logic w_unused_e;
    assign w_unused_e = w_e;
    assign w_rd_step  = 1'b0;
    assign data_out   = 8'h00;
    assign data_oe    = 1'b0;
`endif
endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder; read checks follow LCD_RESP_READ_EN.
`timescale 1ns/1ps
module tb_lcd_bus_responder;
    import lcd_pkg::*;

    localparam int BUSY_N = 2000;
    localparam int LONG_N = 8200;
`ifdef LCD_RESP_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RS = 1'b0, RW = 1'b0, E = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [6:0] disp_rd_addr = 7'd0;
    logic [7:0] data_out, disp_rd_data;
    logic       data_oe, busy, err_busy;
    logic [6:0] ac;
    logic       disp_on, cursor_on, blink_on, id_inc, shift_en, dl_8bit, n_lines;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    lcd_bus_responder #(.BUSY_CYCLES(BUSY_N), .LONG_BUSY_CYCLES(LONG_N)) dut (
        .clk(clk), .rst(rst), .RS(RS), .RW(RW), .E(E), .data_in(data_in),
        .data_out(data_out), .data_oe(data_oe), .busy(busy), .ac(ac),
        .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .id_inc(id_inc), .shift_en(shift_en), .dl_8bit(dl_8bit), .n_lines(n_lines),
        .disp_rd_addr(disp_rd_addr), .disp_rd_data(disp_rd_data), .err_busy(err_busy)
    );

    task automatic bus_cycle(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        RS = rs; RW = rw; data_in = d;
        repeat (2) @(negedge clk);
        E = 1'b1;
        repeat (5) @(negedge clk);
        E = 1'b0;
    endtask

    task automatic measure_busy(output int n);
        int t;
        t = 0;
        n = 0;
        while (!busy && t < 20) begin @(negedge clk); t++; end
        while (busy && n < LONG_N + 400) begin n++; @(negedge clk); end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        repeat (6) @(negedge clk);
        while (busy && n < LONG_N + 400) begin n++; @(negedge clk); end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle timeout: busy=%b after %0d cycles", name, busy, n);
        end
    endtask

    task automatic read_ram(input logic [6:0] a, output logic [7:0] v);
        disp_rd_addr = a;
        repeat (2) @(negedge clk);
        v = disp_rd_data;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, disp_on, cursor_on, blink_on, id_inc, shift_en, dl_8bit, n_lines, data_oe, err_busy} !== 10'b0000101000) begin
            errors++;
            $display("FAIL reset_flags: got %b want %b",
                {busy, disp_on, cursor_on, blink_on, id_inc, shift_en, dl_8bit, n_lines, data_oe, err_busy}, 10'b0000101000);
        end
        checks++;
        if (ac !== 7'd0) begin errors++; $display("FAIL reset_ac: got %h want 00", ac); end
        checks++;
        if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    endtask

    task automatic test_function_display();
        int n;
        bus_cycle(1'b0, 1'b0, 8'h38);
        measure_busy(n);
        checks++;
        if (n !== BUSY_N) begin errors++; $display("FAIL busy_len_38: got %0d want %0d", n, BUSY_N); end
        checks++;
        if ({dl_8bit, n_lines} !== 2'b11) begin errors++; $display("FAIL func_set: got %b want 11", {dl_8bit, n_lines}); end
        bus_cycle(1'b0, 1'b0, 8'h0C);
        measure_busy(n);
        checks++;
        if (n !== BUSY_N) begin errors++; $display("FAIL busy_len_0C: got %0d want %0d", n, BUSY_N); end
        checks++;
        if ({disp_on, cursor_on, blink_on} !== 3'b100) begin
            errors++; $display("FAIL disp_ctrl: got %b want 100", {disp_on, cursor_on, blink_on});
        end
    endtask

    task automatic test_busy_write();
        bus_cycle(1'b0, 1'b0, 8'h06);
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_06: got %b want 1", busy); end
        bus_cycle(1'b0, 1'b0, 8'hC5);
        repeat (6) @(negedge clk);
        checks++;
        if ({err_busy, ac} !== {1'b1, 7'd0}) begin
            errors++; $display("FAIL busy_write: got err=%b ac=%h want err=1 ac=00", err_busy, ac);
        end
        wait_idle("entry_06");
        checks++;
        if ({err_busy, ac, id_inc, shift_en} !== {1'b1, 7'd0, 2'b10}) begin
            errors++; $display("FAIL busy_write_after: got err=%b ac=%h id=%b s=%b want 1 00 1 0",
                err_busy, ac, id_inc, shift_en);
        end
    endtask

    task automatic test_data_wrap();
        logic [7:0] v;
        bus_cycle(1'b0, 1'b0, 8'hCF);
        wait_idle("set_ac_79");
        checks++;
        if (ac !== 7'd79) begin errors++; $display("FAIL set_ac_79: got %0d want 79", ac); end
        bus_cycle(1'b1, 1'b0, 8'h50);
        wait_idle("data_50");
        checks++;
        if (ac !== 7'd0) begin errors++; $display("FAIL ac_wrap_up: got %0d want 0", ac); end
        read_ram(7'd79, v);
        checks++;
        if (v !== 8'h50) begin errors++; $display("FAIL ddram_79: got %h want 50", v); end
    endtask

    task automatic test_data_read();
        bus_cycle(1'b1, 1'b0, 8'h11);
        wait_idle("data_11");
        bus_cycle(1'b0, 1'b0, 8'h80);
        wait_idle("set_ac_0");
        @(negedge clk);
        RS = 1'b1; RW = 1'b1; data_in = 8'h00;
        repeat (2) @(negedge clk);
        E = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if ({data_oe, data_out} !== (READ_EN ? 9'h111 : 9'h000)) begin
            errors++; $display("FAIL data_read: got oe=%b out=%h want %h", data_oe, data_out, READ_EN ? 9'h111 : 9'h000);
        end
        E = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if ({data_oe, busy, ac} !== {2'b00, READ_EN ? 7'd1 : 7'd0}) begin
            errors++; $display("FAIL data_read_step: got oe=%b busy=%b ac=%h want 0 0 %h",
                data_oe, busy, ac, READ_EN ? 7'd1 : 7'd0);
        end
    endtask

    task automatic test_clamp_decrement();
        logic [7:0] v;
        bus_cycle(1'b0, 1'b0, 8'hFF);
        wait_idle("set_ac_ff");
        checks++;
        if (ac !== 7'd79) begin errors++; $display("FAIL ac_clamp: got %0d want 79", ac); end
        bus_cycle(1'b0, 1'b0, 8'h80);
        wait_idle("set_ac_00");
        bus_cycle(1'b0, 1'b0, 8'h04);
        wait_idle("entry_04");
        checks++;
        if (id_inc !== 1'b0) begin errors++; $display("FAIL entry_dec: got %b want 0", id_inc); end
        bus_cycle(1'b1, 1'b0, 8'h22);
        wait_idle("data_22");
        checks++;
        if (ac !== 7'd79) begin errors++; $display("FAIL ac_wrap_down: got %0d want 79", ac); end
        read_ram(7'd0, v);
        checks++;
        if (v !== 8'h22) begin errors++; $display("FAIL ddram_0: got %h want 22", v); end
    endtask

    task automatic test_read_busy();
        bus_cycle(1'b0, 1'b0, 8'hC5);
        repeat (8) @(negedge clk);
        RS = 1'b0; RW = 1'b1;
        repeat (2) @(negedge clk);
        E = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if ({busy, data_oe, data_out} !== (READ_EN ? 10'h3C5 : 10'h200)) begin
            errors++; $display("FAIL status_read: got busy=%b oe=%b out=%h want oe=%b out=%h",
                busy, data_oe, data_out, READ_EN, READ_EN ? 8'hC5 : 8'h00);
        end
        E = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if ({data_oe, ac} !== {1'b0, 7'h45}) begin
            errors++; $display("FAIL status_read_end: got oe=%b ac=%h want 0 45", data_oe, ac);
        end
        wait_idle("set_ac_45");
    endtask

    task automatic test_clear();
        int n, bad;
        logic [7:0] v;
        bus_cycle(1'b0, 1'b0, 8'h01);
        measure_busy(n);
        checks++;
        if (n !== 80 + LONG_N) begin errors++; $display("FAIL busy_len_clear: got %0d want %0d", n, 80 + LONG_N); end
        checks++;
        if ({ac, id_inc} !== {7'd0, 1'b1}) begin
            errors++; $display("FAIL clear_ac_id: got ac=%h id=%b want 00 1", ac, id_inc);
        end
        bad = 0;
        for (int a = 0; a < DDRAM_DEPTH; a++) begin
            read_ram(7'(a), v);
            if (v !== 8'h20) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL clear_fill: got %0d bad addresses want 0", bad); end
    endtask

    task automatic test_reset_mid_clear();
        int t, n;
        bus_cycle(1'b0, 1'b0, 8'h01);
        t = 0;
        while (!busy && t < 20) begin @(negedge clk); t++; end
        repeat (40) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, dut.r_state == ST_IDLE, n_lines} !== 3'b010) begin
            errors++; $display("FAIL reset_mid_clear: got busy=%b idle=%b n=%b want 0 1 0",
                busy, dut.r_state == ST_IDLE, n_lines);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        bus_cycle(1'b0, 1'b0, 8'h38);
        measure_busy(n);
        checks++;
        if (n !== BUSY_N) begin errors++; $display("FAIL post_reset_strobe: got %0d want %0d", n, BUSY_N); end
        checks++;
        if (n_lines !== 1'b1) begin errors++; $display("FAIL post_reset_func: got %b want 1", n_lines); end
    endtask

    initial begin
        test_reset();
        test_function_display();
        test_busy_write();
        test_data_wrap();
        test_data_read();
        test_clamp_decrement();
        test_read_busy();
        test_clear();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lcd_bus_responder.md
LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 2000, clk cycles busy after a normal command or data write (40 us at 50 MHz).
REQ-002 SHALL have parameter LONG_BUSY_CYCLES, default 82000, clk cycles busy after clear or home (1.64 ms).
REQ-003 SHALL have port clk  input  1  50 MHz system clock; one clock domain only.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port RS  input  1  register select from the LCD initiator: 0 = instruction, 1 = data.
REQ-006 SHALL have port RW  input  1  read/write from the initiator: 0 = write, 1 = read.
REQ-007 SHALL have port E  input  1  enable strobe, asynchronous to clk.
REQ-008 SHALL have port data_in  input  8  bus value driven by the initiator.
REQ-009 SHALL have port data_out  output  8  bus value returned on reads.
REQ-010 SHALL have port data_oe  output  1  bus drive enable for data_out.
REQ-011 SHALL have port busy  output  1  busy flag (BF).
REQ-012 SHALL have port ac  output  7  address counter.
REQ-013 SHALL have port disp_on, cursor_on, blink_on  output  1 each  display control bits D, C, B.
REQ-014 SHALL have port id_inc, shift_en  output  1 each  entry mode bits I/D, S.
REQ-015 SHALL have port dl_8bit, n_lines  output  1 each  function set bits DL, N.
REQ-016 SHALL have port disp_rd_addr  input  7  / disp_rd_data  output  8  second, read-only DDRAM port; 1-cycle registered latency.
REQ-017 SHALL have port err_busy  output  1  sticky flag, set by any write accepted while busy.

Function
REQ-018 SHALL pass E, RS, RW and data_in through a 2-flop synchronizer; a strobe is the falling edge of synchronized E; RS, RW and data are sampled from the same synchronized cycle.
REQ-019 SHALL run the FSM IDLE -> DECODE (1 cycle after strobe) -> EXEC (clear only) -> BUSY -> IDLE when the busy counter reaches 0.
REQ-020 SHALL assert busy from DECODE until the counter expires; the counter loads BUSY_CYCLES or LONG_BUSY_CYCLES and is 17 bits wide.
REQ-021 SHALL ignore a write strobe while busy=1, with no state change, and set err_busy.
REQ-022 SHALL decode RS=0/RW=0 by leading one: 0x01 clear; 0x02/0x03 home (ac=0); 0000_01IS entry mode; 0000_1DCB display control; 0001_xxxx shift (accepted, no effect except busy); 001x_xxxx function set (DL=bit4, N=bit3); 01xx_xxxx CGRAM (accepted, no effect); 1aaa_aaaa set ac=a; 0x00 ignored with no busy.
REQ-023 SHALL make clear write 0x20 to DDRAM addresses 0..79, one per cycle in EXEC (80 cycles), then set ac=0 and id_inc=1; busy SHALL span EXEC plus LONG_BUSY_CYCLES.
REQ-024 SHALL handle RS=1/RW=0 by writing data_in to DDRAM[ac], then stepping ac +1 (id_inc=1) or -1.
REQ-025 SHALL wrap ac within 0..79: 79+1 -> 0 and 0-1 -> 79; set-address values above 79 SHALL clamp to 79.
REQ-026 SHALL handle RS=0/RW=1 with data_out={busy,ac} and data_oe=1 while synchronized E=1; this read is allowed while busy and does not change state.
REQ-027 SHALL handle RS=1/RW=1 with data_out=DDRAM[ac] and data_oe=1 while synchronized E=1; on the strobe, ac steps as in REQ-024; the read is ignored (no step) while busy.
REQ-028 SHALL keep data_oe=0 whenever RW=0 or synchronized E=0.

Reset
REQ-029 SHALL, on rst low: FSM to IDLE, busy=0, ac=0, disp_on=cursor_on=blink_on=0, id_inc=1, shift_en=0, dl_8bit=1, n_lines=0, data_out=0, data_oe=0, err_busy=0, synchronizers to 0.
REQ-030 SHALL abort a clear or busy count in progress when reset is applied mid-operation; DDRAM contents are not reset.

Configuration
REQ-031 SHALL, with LCD_RESP_READ_EN defined, implement REQ-026/027; without it, data_oe SHALL be tied to 0, data_out to 0, and RW=1 strobes ignored.

Structure
REQ-032 SHALL place the state_t enum, command opcode/mask constants and DDRAM_DEPTH=80 in a shared package lcd_pkg.
REQ-033 SHALL instantiate one sub-module, lcd_sync, which contains the 2-flop synchronizer and E falling-edge detector; DDRAM SHALL be an 80x8 inferred dual-port RAM.

Verification
REQ-034 SHALL cover: after reset, strobe 0x38 then 0x0C -> dl_8bit=1, n_lines=1, disp_on=1, cursor_on=0; busy high for 2000 cycles after each strobe.
REQ-035 SHALL cover: strobe 0x06, then data 0x50 at ac=79 -> DDRAM[79]=0x50, ac=0.
REQ-036 SHALL cover: strobe 0x01 -> busy for 80+82000 cycles; disp_rd_data=0x20 at all 80 addresses; ac=0.
REQ-037 SHALL cover: a write strobe 0xC5 while busy -> ac unchanged, err_busy=1 and staying set.
REQ-038 SHALL cover, with LCD_RESP_READ_EN: RS=0/RW=1 read mid-busy at ac=0x45 -> data_out=0xC5, data_oe=1 only while E high.
REQ-039 SHALL cover: reset asserted 40 cycles into a clear -> busy=0, FSM IDLE, next strobe accepted.
